image_frame_receiver: RTL and testbench

//  Avalon-ST video sink: receiving end of the 12-bit RGB444 pixel stream (sop/eop/valid/ready).

---
 rtl/image_stream_pkg.sv | 17 +
 rtl/frame_pixel_counter.sv | 40 ++++
 rtl/image_frame_receiver.sv | 160 ++++++++++++++++
 tb/tb_image_frame_receiver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_stream_pkg.sv
// Shared types and defaults for the RGB444 image stream (send and receive sides).
package image_stream_pkg;

    localparam int PIXEL_W   = 12;
    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;

    typedef logic [PIXEL_W-1:0] rgb444_t;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN,
        HOLD
    } rx_state_t;

endpackage

// File: rtl/frame_pixel_counter.sv
// Pixel counter for one frame: clear / load-1 / increment, flags for last and full.
module frame_pixel_counter #(
    parameter int ADDR_W = 17,
    parameter int TOTAL  = 76800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load_one,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              full
);

    // One extra bit so that TOTAL itself is representable.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (load_one) begin
            cnt_reg <= ONE_C;
        end else if (inc) begin
            cnt_reg <= cnt_reg + ONE_C;
        end
    end

    assign addr = cnt_reg[ADDR_W-1:0];
    assign last = (cnt_reg == LAST_C);
    assign full = (cnt_reg == TOTAL_C);

endmodule

// File: rtl/image_frame_receiver.sv
// Avalon-ST RGB444 video sink: stores one frame into a buffer write port,
// flags good/malformed frames, then holds the link until the consumer acks.
module image_frame_receiver #(
    parameter int PIXEL_W = image_stream_pkg::PIXEL_W,
    parameter int IMG_W   = image_stream_pkg::DEF_IMG_W,
    parameter int IMG_H   = image_stream_pkg::DEF_IMG_H,
    parameter int ADDR_W  = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIXEL_W-1:0] data_in,
    input  logic               valid,
    input  logic               sop,
    input  logic               eop,
    output logic               ready,
    input  logic               frame_ack,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PIXEL_W-1:0] wr_data,
    output logic               frame_received,
    output logic               frame_error,
    output logic [7:0]         frame_count
);

    import image_stream_pkg::*;

    localparam int TOTAL = IMG_W * IMG_H;

    rx_state_t          state_reg, state_next;
    logic               ready_reg;
    logic               wr_en_reg;
    logic [ADDR_W-1:0]  wr_addr_reg;
    logic [PIXEL_W-1:0] wr_data_reg;
    logic               frame_received_reg;
    logic               frame_error_reg;
    logic [7:0]         frame_count_reg;

    logic              accept;
    logic              cnt_clear, cnt_load, cnt_inc;
    logic              wr_go, wr_zero, good_go, err_go;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_last, cnt_full;

    frame_pixel_counter #(
        .ADDR_W (ADDR_W),
        .TOTAL  (TOTAL)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .load_one (cnt_load),
        .inc      (cnt_inc),
        .addr     (cnt_addr),
        .last     (cnt_last),
        .full     (cnt_full)
    );

    assign accept = valid && ready_reg;

    always_comb begin
        state_next = state_reg;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        wr_go      = 1'b0;
        wr_zero    = 1'b0;
        good_go    = 1'b0;
        err_go     = 1'b0;

        if (state_reg == HOLD) begin
            if (frame_ack) begin
                state_next = IDLE;
                cnt_clear  = 1'b1;
            end
        end else if (accept) begin
            if (sop) begin
                // A sop always starts a fresh frame; abandoning one in flight is an error.
                wr_go    = 1'b1;
                wr_zero  = 1'b1;
                cnt_load = 1'b1;
                err_go   = (state_reg != IDLE);
                if (eop) begin
                    if (TOTAL == 1) begin
                        good_go    = 1'b1;
                        state_next = HOLD;
                    end else begin
                        err_go     = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    state_next = RECV;
                end
            end else if (state_reg == RECV) begin
                if (cnt_full) begin
                    // Overlong: nothing past the last address is written.
                    if (eop) begin
                        err_go     = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DRAIN;
                    end
                end else begin
                    wr_go   = 1'b1;
                    cnt_inc = 1'b1;
                    if (eop) begin
                        if (cnt_last) begin
                            good_go    = 1'b1;
                            state_next = HOLD;
                        end else begin
                            err_go     = 1'b1;
                            cnt_clear  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end else if (state_reg == DRAIN && eop) begin
                err_go     = 1'b1;
                cnt_clear  = 1'b1;
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            ready_reg          <= 1'b0;
            wr_en_reg          <= 1'b0;
            wr_addr_reg        <= '0;
            wr_data_reg        <= '0;
            frame_received_reg <= 1'b0;
            frame_error_reg    <= 1'b0;
            frame_count_reg    <= '0;
        end else begin
            state_reg          <= state_next;
            ready_reg          <= (state_next != HOLD);
            wr_en_reg          <= wr_go;
            frame_received_reg <= good_go;
            frame_error_reg    <= err_go;
            if (wr_go) begin
                wr_addr_reg <= wr_zero ? '0 : cnt_addr;
                wr_data_reg <= data_in;
            end
            if (good_go) begin
                frame_count_reg <= frame_count_reg + 8'd1;
            end
        end
    end

    assign ready          = ready_reg;
    assign wr_en          = wr_en_reg;
    assign wr_addr        = wr_addr_reg;
    assign wr_data        = wr_data_reg;
    assign frame_received = frame_received_reg;
    assign frame_error    = frame_error_reg;
    assign frame_count    = frame_count_reg;

endmodule

// File: tb/tb_image_frame_receiver.sv
// Randomized bench for image_frame_receiver on a 4x2 frame, against a frame-level reference model.
module tb_image_frame_receiver;

    localparam int TOTAL = 8;

    logic        clk;
    logic        rst_n;
    logic [11:0] data_in;
    logic        valid, sop, eop, frame_ack;
    logic        ready, wr_en, frame_received, frame_error;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic [7:0]  frame_count;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: frame-level bookkeeping
    bit       m_ready, m_in_frame, m_drop, m_hold;
    int       m_pix;
    bit [7:0] m_fc;

    image_frame_receiver #(
        .PIXEL_W (12),
        .IMG_W   (4),
        .IMG_H   (2),
        .ADDR_W  (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .valid          (valid),
        .sop            (sop),
        .eop            (eop),
        .ready          (ready),
        .frame_ack      (frame_ack),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .frame_received (frame_received),
        .frame_error    (frame_error),
        .frame_count    (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare registered outputs.
    task automatic step(input bit v, input bit s, input bit e, input logic [11:0] d, input bit ack);
        bit          acc, e_wr, e_good, e_err;
        logic [2:0]  e_addr;
        valid = v; sop = s; eop = e; data_in = d; frame_ack = ack;
        acc = v && m_ready;
        e_wr = 0; e_good = 0; e_err = 0; e_addr = '0;
        if (m_hold) begin
            if (ack) begin
                m_hold = 0;
                m_pix  = 0;
            end
        end else if (acc) begin
            if (s) begin
                e_err = m_in_frame || m_drop;
                e_wr = 1; e_addr = 3'd0;
                m_pix = 1; m_drop = 0; m_in_frame = 1;
                if (e) begin
                    m_in_frame = 0;
                    if (m_pix == TOTAL) e_good = 1; else e_err = 1;
                end
            end else if (m_in_frame) begin
                if (m_pix == TOTAL) begin
                    m_in_frame = 0;
                    if (e) e_err = 1; else m_drop = 1;
                end else begin
                    e_wr = 1; e_addr = 3'(m_pix);
                    m_pix++;
                    if (e) begin
                        m_in_frame = 0;
                        if (m_pix == TOTAL) e_good = 1; else e_err = 1;
                    end
                end
            end else if (m_drop && e) begin
                e_err  = 1;
                m_drop = 0;
            end
        end
        if (e_good) begin
            m_hold = 1;
            m_fc++;
        end
        m_ready = !m_hold;
        @(posedge clk);
        #1;
        check("ready", ready, m_ready);
        check("wr_en", wr_en, e_wr);
        check("frame_received", frame_received, e_good);
        check("frame_error", frame_error, e_err);
        check("frame_count", frame_count, m_fc);
        if (e_wr) begin
            check("wr_addr", wr_addr, e_addr);
            check("wr_data", wr_data, d);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; valid = 0; sop = 0; eop = 0; frame_ack = 0; data_in = '0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_pulses", {frame_received, frame_error}, 0);
        check("rst_count", frame_count, 0);
        m_ready = 0; m_in_frame = 0; m_drop = 0; m_hold = 0; m_pix = 0; m_fc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_ready", ready, 0);
        check("rst_hold_wr_en", wr_en, 0);
        rst_n = 1;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle before every beat, 2 random idles
    task automatic beat(input bit s, input bit e, input logic [11:0] d, input int gap_mode);
        int tries = 0;
        if (gap_mode == 1) begin
            step(0, 1, 1, 12'($urandom), 0);
        end else if (gap_mode == 2) begin
            while ($urandom_range(0, 2) == 0 && tries < 4) begin
                step(0, 1'($urandom), 1'($urandom), 12'($urandom), 0);
                tries++;
            end
        end
        tries = 0;
        while (!m_ready && tries < 20) begin
            step(0, 0, 0, 12'd0, 0);
            tries++;
        end
        if (!m_ready) begin
            check("beat_timeout", m_ready, 1);
            return;
        end
        step(1, s, e, d, 0);
    endtask

    task automatic send_frame(input int n, input int eop_at, input int sop2_at,
                              input int gap_mode, input bit rand_data);
        logic [11:0] d;
        for (int i = 1; i <= n; i++) begin
            d = rand_data ? 12'($urandom) : 12'(i);
            beat(i == 1 || i == sop2_at, i == eop_at, d, gap_mode);
        end
    endtask

    task automatic ack();
        step(0, 0, 0, 12'd0, 1);
    endtask

    initial begin
        bit [7:0] fc_before;
        rst_n = 0; valid = 0; sop = 0; eop = 0; frame_ack = 0; data_in = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Beat without sop in IDLE is discarded.
        step(1, 0, 1, 12'h123, 0);

        // 1: good frame, then beats and idle cycles while holding
        send_frame(8, 8, 0, 0, 0);
        check("t1_count", frame_count, 8'd1);
        step(1, 1, 0, 12'h0AA, 0);
        step(1, 0, 1, 12'h0BB, 0);
        check("t1_hold_ready", ready, 0);
        ack();

        // 2: same frame, valid alternating
        send_frame(8, 8, 0, 1, 0);
        ack();

        // 3: short frame; stray ack outside HOLD is ignored
        send_frame(5, 5, 0, 0, 0);
        step(0, 0, 0, 12'd0, 1);
        check("t3_ready", ready, 1);

        // 4: overlong frame
        fc_before = m_fc;
        send_frame(10, 10, 0, 0, 1);
        check("t4_count", frame_count, fc_before);

        // 5: restart at beat 4, then 8 good beats
        send_frame(11, 11, 4, 0, 1);
        ack();

        // 6: reset mid-frame, then a good frame
        send_frame(2, 0, 0, 0, 1);
        do_reset();
        send_frame(8, 8, 0, 2, 1);
        check("t6_count", frame_count, 8'd1);
        ack();

        // 7: 256 good frames wrap the counter back to its start value
        fc_before = m_fc;
        for (int f = 0; f < 256; f++) begin
            send_frame(8, 8, 0, 2, 1);
            ack();
        end
        check("t7_wrap", frame_count, fc_before);

        // Random mix of sop/eop/valid/ack
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 6) == 0, 12'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
